// File: rtl/ai_accel_pkg.sv
// Shared constants and types for the AI accelerator Wishbone responder.
// Provides register index map, STATUS bit positions, decoded region type
// and the bus FSM state type.
package ai_accel_pkg;

    // Register window word indices
    localparam int unsigned IDX_OP   = 0;
    localparam int unsigned IDX_WA   = 1;
    localparam int unsigned IDX_HA   = 2;
    localparam int unsigned IDX_WB   = 3;
    localparam int unsigned IDX_HB   = 4;
    localparam int unsigned IDX_GO   = 5;
    localparam int unsigned IDX_MEM0 = 6;

    // STATUS register bit positions
    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_DONE = 1;
    localparam int unsigned ST_ERR  = 2;

    typedef enum logic [2:0] {
        RGN_CTRL,
        RGN_GO,
        RGN_MEM,
        RGN_RES,
        RGN_NONE
    } region_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_HOLD
    } state_t;

endpackage

// File: rtl/ai_accel_addr_decode.sv
// Combinational address decoder for the accelerator window.
// Ports:
//   addr     - Wishbone byte address
//   region   - decoded region (control, GO/STATUS, operand RAM, result RAM, unmapped)
//   ctrl_idx - control register index (valid for RGN_CTRL)
//   mem_idx  - operand RAM word index (valid for RGN_MEM)
//   res_idx  - result RAM word index (valid for RGN_RES)
module ai_accel_addr_decode
    import ai_accel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3200_0000,
    parameter int unsigned IN_MEM_SIZE  = 64,
    parameter int unsigned OUT_MEM_SIZE = 32
) (
    input  logic [31:0]                     addr,
    output region_t                         region,
    output logic [2:0]                      ctrl_idx,
    output logic [$clog2(IN_MEM_SIZE)-1:0]  mem_idx,
    output logic [$clog2(OUT_MEM_SIZE)-1:0] res_idx
);

    localparam int unsigned MAW = $clog2(IN_MEM_SIZE);
    localparam int unsigned RAW = $clog2(OUT_MEM_SIZE);

    logic [31:0] idx;

    // Addresses below BASE_ADDR wrap to a huge index and fall into unmapped.
    assign idx      = (addr - BASE_ADDR) >> 2;
    assign ctrl_idx = idx[2:0];
    assign mem_idx  = idx[MAW-1:0];
    assign res_idx  = RAW'(idx - IN_MEM_SIZE);

    always_comb begin
        region = RGN_NONE;
        if (idx < IDX_GO)
            region = RGN_CTRL;
        else if (idx == IDX_GO)
            region = RGN_GO;
        else if (idx < IN_MEM_SIZE)
            region = RGN_MEM;
        else if (idx < IN_MEM_SIZE + OUT_MEM_SIZE)
            region = RGN_RES;
    end

endmodule

// File: rtl/ai_accel_wb_responder.sv
// Wishbone slave front-end for the AI accelerator: control registers,
// GO/STATUS, operand RAM write/read and result RAM read.
// Ports:
//   wb_clk_i, wb_rst_i (sync, active-low)
//   wb_addr_i/wb_we_i/wb_data_i/wb_stb -> request; wb_data_o/wb_ack -> response
//   op_o, wa_o, ha_o, wbm_o, hbm_o     -> control register values
//   start_o / core_done_i              -> core handshake
//   mem_addr_o/mem_we_o/mem_wdata_o/mem_rdata_i -> operand RAM (1-cycle read)
//   res_addr_o/res_rdata_i             -> result RAM (1-cycle read)
module ai_accel_wb_responder
    import ai_accel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3200_0000,
    parameter int unsigned IN_MEM_SIZE  = 64,
    parameter int unsigned OUT_MEM_SIZE = 32,
    parameter int unsigned TYPE_BW      = 16
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic [31:0]                     wb_addr_i,
    input  logic                            wb_we_i,
    input  logic [31:0]                     wb_data_i,
    input  logic                            wb_stb,
    output logic [31:0]                     wb_data_o,
    output logic                            wb_ack,
    output logic [7:0]                      op_o,
    output logic [7:0]                      wa_o,
    output logic [7:0]                      ha_o,
    output logic [7:0]                      wbm_o,
    output logic [7:0]                      hbm_o,
    output logic                            start_o,
    input  logic                            core_done_i,
    output logic [$clog2(IN_MEM_SIZE)-1:0]  mem_addr_o,
    output logic                            mem_we_o,
    output logic [TYPE_BW-1:0]              mem_wdata_o,
    input  logic [TYPE_BW-1:0]              mem_rdata_i,
    output logic [$clog2(OUT_MEM_SIZE)-1:0] res_addr_o,
    input  logic [TYPE_BW-1:0]              res_rdata_i
);

    state_t      state;
    region_t     region;
    logic [2:0]  ctrl_idx;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^wb_data_i[31:TYPE_BW];

    ai_accel_addr_decode #(
        .BASE_ADDR   (BASE_ADDR),
        .IN_MEM_SIZE (IN_MEM_SIZE),
        .OUT_MEM_SIZE(OUT_MEM_SIZE)
    ) u_decode (
        .addr    (wb_addr_i),
        .region  (region),
        .ctrl_idx(ctrl_idx),
        .mem_idx (mem_addr_o),
        .res_idx (res_addr_o)
    );

    // RAM addresses are decoded straight from the held request address, so
    // read data is already valid in REQ and can be captured on entry to ACK.
    always_comb begin
        rdata = '0;
        case (region)
            RGN_CTRL: begin
                case (ctrl_idx)
                    3'(IDX_OP): rdata[7:0] = op_o;
                    3'(IDX_WA): rdata[7:0] = wa_o;
                    3'(IDX_HA): rdata[7:0] = ha_o;
                    3'(IDX_WB): rdata[7:0] = wbm_o;
                    3'(IDX_HB): rdata[7:0] = hbm_o;
                    default:    rdata = '0;
                endcase
            end
            RGN_GO: begin
                rdata[ST_BUSY] = busy;
                rdata[ST_DONE] = done;
                rdata[ST_ERR]  = err;
            end
            RGN_MEM: rdata = {{(32-TYPE_BW){mem_rdata_i[TYPE_BW-1]}}, mem_rdata_i};
            RGN_RES: rdata = {{(32-TYPE_BW){res_rdata_i[TYPE_BW-1]}}, res_rdata_i};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state       <= S_IDLE;
            wb_ack      <= 1'b0;
            wb_data_o   <= '0;
            start_o     <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= '0;
            op_o        <= '0;
            wa_o        <= '0;
            ha_o        <= '0;
            wbm_o       <= '0;
            hbm_o       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            wb_ack   <= 1'b0;
            start_o  <= 1'b0;
            mem_we_o <= 1'b0;

            if (core_done_i) begin
                busy <= 1'b0;
                done <= 1'b1;
            end

            case (state)
                // The access is launched on the edge that leaves IDLE so that
                // start_o / mem_we_o are high during the REQ cycle itself; a
                // GO here is placed after core_done_i handling so GO wins.
                S_IDLE: begin
                    if (wb_stb) begin
                        state <= S_REQ;
                        if (wb_we_i) begin
                            if (busy && (region == RGN_CTRL || region == RGN_GO ||
                                         region == RGN_MEM)) begin
                                err <= 1'b1;
                            end else begin
                                case (region)
                                    RGN_CTRL: begin
                                        case (ctrl_idx)
                                            3'(IDX_OP): op_o  <= wb_data_i[7:0];
                                            3'(IDX_WA): wa_o  <= wb_data_i[7:0];
                                            3'(IDX_HA): ha_o  <= wb_data_i[7:0];
                                            3'(IDX_WB): wbm_o <= wb_data_i[7:0];
                                            3'(IDX_HB): hbm_o <= wb_data_i[7:0];
                                            default: ;
                                        endcase
                                    end
                                    RGN_GO: begin
                                        start_o <= 1'b1;
                                        busy    <= 1'b1;
                                        done    <= 1'b0;
                                        err     <= 1'b0;
                                    end
                                    RGN_MEM: begin
                                        mem_we_o    <= 1'b1;
                                        mem_wdata_o <= wb_data_i[TYPE_BW-1:0];
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                S_REQ: begin
                    state     <= S_ACK;
                    wb_ack    <= 1'b1;
                    wb_data_o <= wb_we_i ? '0 : rdata;
                end
                S_ACK:  state <= S_HOLD;
                S_HOLD: if (!wb_stb) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ai_accel_wb_responder.sv
// Self-checking bench for ai_accel_wb_responder: transaction-level model of
// the register/memory map plus per-cycle checks of idle outputs.
module tb_ai_accel_wb_responder;

    localparam logic [31:0] BASE = 32'h3200_0000;
    localparam int unsigned INS  = 64;
    localparam int unsigned OUTS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic        stb = 1'b0;
    logic [31:0] data_o;
    logic        ack;
    logic [7:0]  op, wa, ha, wbm, hbm;
    logic        start;
    logic        core_done = 1'b0;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [4:0]  res_addr;
    logic [15:0] res_rdata = '0;

    always #5 clk = ~clk;

    ai_accel_wb_responder #(
        .BASE_ADDR   (BASE),
        .IN_MEM_SIZE (INS),
        .OUT_MEM_SIZE(OUTS),
        .TYPE_BW     (16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .wb_addr_i  (addr),
        .wb_we_i    (we),
        .wb_data_i  (wdata),
        .wb_stb     (stb),
        .wb_data_o  (data_o),
        .wb_ack     (ack),
        .op_o       (op),
        .wa_o       (wa),
        .ha_o       (ha),
        .wbm_o      (wbm),
        .hbm_o      (hbm),
        .start_o    (start),
        .core_done_i(core_done),
        .mem_addr_o (mem_addr),
        .mem_we_o   (mem_we),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .res_addr_o (res_addr),
        .res_rdata_i(res_rdata)
    );

    // Environment RAMs with 1-cycle read latency
    logic [15:0] op_ram [INS] = '{default: '0};
    logic [15:0] res_ram [OUTS];

    always @(posedge clk) begin
        if (mem_we) op_ram[mem_addr] <= mem_wdata;
        mem_rdata <= op_ram[mem_addr];
        res_rdata <= res_ram[res_addr];
    end

    // Behavioural model
    logic [7:0]  m_ctrl [5];
    logic        m_busy, m_done, m_err;
    logic [15:0] m_mem [INS];

    int tests = 0;
    int fails = 0;
    logic in_txn = 1'b1;

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) m_ctrl[i] = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - BASE) >> 2;
        if (idx < 5)            return {24'h0, m_ctrl[idx]};
        if (idx == 5)           return {29'h0, m_err, m_done, m_busy};
        if (idx < INS)          return 32'($signed(m_mem[idx]));
        if (idx < INS + OUTS)   return 32'($signed(res_ram[idx - INS]));
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] idx;
        idx = (a - BASE) >> 2;
        if (m_busy && idx < INS) begin
            m_err = 1'b1;
        end else if (idx < 5) begin
            m_ctrl[idx] = d[7:0];
        end else if (idx == 5) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_err  = 1'b0;
        end else if (idx < INS) begin
            m_mem[idx] = d[15:0];
        end
    endfunction

    // Outside transactions: control outputs follow the model, strobes are quiet
    always @(negedge clk) begin
        if (rst_n && !in_txn)
            check("idle_outputs", {21'h0, op, wa, ha, wbm, hbm, ack, start, mem_we},
                  {21'h0, m_ctrl[0], m_ctrl[1], m_ctrl[2], m_ctrl[3], m_ctrl[4], 3'b000});
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd);
        logic [31:0] idx;
        logic [31:0] exp_rd;
        logic        exp_start, exp_mwe;
        int          ack_cyc;
        idx       = (a - BASE) >> 2;
        exp_rd    = model_read(a);
        exp_start = w && idx == 5 && !m_busy;
        exp_mwe   = w && idx >= 6 && idx < INS && !m_busy;
        in_txn = 1'b1;
        addr = a; we = w; wdata = d; stb = 1'b1;
        ack_cyc = -1;
        for (int c = 0; c < 6 && ack_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                check("start_o", 64'(start), 64'(exp_start));
                check("mem_we_o", 64'(mem_we), 64'(exp_mwe));
                if (exp_mwe) begin
                    check("mem_addr_o", 64'(mem_addr), 64'(idx[5:0]));
                    check("mem_wdata_o", 64'(mem_wdata), 64'(d[15:0]));
                end
            end else begin
                check("strobes_after_req", {62'h0, start, mem_we}, 64'h0);
            end
            if (ack === 1'b1) ack_cyc = c;
        end
        check("ack_latency", 64'(ack_cyc), 64'(1));
        rd = data_o;
        if (!w) check("read_data", 64'(data_o), 64'(exp_rd));
        stb = 1'b0;
        @(posedge clk); #1;
        check("ack_single_cycle", 64'(ack), 64'h0);
        check("data_hold", 64'(data_o), 64'(rd));
        @(posedge clk); #1;
        if (w) model_write(a, d);
        in_txn = 1'b0;
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b1;
    endtask

    task automatic reset_during_req();
        int ack_cyc;
        in_txn = 1'b1;
        addr = BASE + 32'd4; we = 1'b0; stb = 1'b1;
        @(posedge clk); #1;
        check("req_no_ack", 64'(ack), 64'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_data", 64'(data_o), 64'h0);
        check("rst_strobes", {62'h0, start, mem_we}, 64'h0);
        check("rst_ctrl", {24'h0, op, wa, ha, wbm, hbm}, 64'h0);
        model_reset();
        rst_n = 1'b1;
        ack_cyc = -1;
        for (int c = 0; c < 6 && ack_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) ack_cyc = c;
        end
        check("rst_fresh_ack_latency", 64'(ack_cyc), 64'(1));
        check("rst_fresh_data", 64'(data_o), 64'h0);
        stb = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_txn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] idx, a;
        int          r;

        model_reset();
        for (int i = 0; i < INS; i++) m_mem[i] = '0;
        for (int i = 0; i < OUTS; i++) res_ram[i] = 16'($urandom);
        res_ram[0] = 16'hFFBC;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {21'h0, op, wa, ha, wbm, hbm, ack, start, mem_we},
              64'h0);
        check("reset_data", 64'(data_o), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_txn = 1'b0;

        // Control register write / read
        do_txn(BASE + 32'd4, 1'b1, 32'h0000_0002, rd);
        do_txn(BASE + 32'd4, 1'b0, 32'h0, rd);
        check("lit_wa_read", 64'(rd), 64'h0000_0002);
        check("lit_wa_o", 64'(wa), 64'h2);

        // Operand RAM sign extension
        do_txn(BASE + 32'd24, 1'b1, 32'h0000_FFFD, rd);
        do_txn(BASE + 32'd24, 1'b0, 32'h0, rd);
        check("lit_mem_read", 64'(rd), 64'hFFFF_FFFD);

        // GO / STATUS / done
        do_txn(BASE + 32'd20, 1'b1, 32'hDEAD_BEEF, rd);
        do_txn(BASE + 32'd20, 1'b0, 32'h0, rd);
        check("lit_status_busy", 64'(rd), 64'h1);
        pulse_done();
        do_txn(BASE + 32'd20, 1'b0, 32'h0, rd);
        check("lit_status_done", 64'(rd), 64'h2);

        // Writes while busy are discarded and flag err
        do_txn(BASE + 32'd20, 1'b1, 32'h0, rd);
        do_txn(BASE + 32'd8, 1'b1, 32'h0000_0007, rd);
        check("lit_ha_unchanged", 64'(ha), 64'h0);
        do_txn(BASE + 32'd20, 1'b0, 32'h0, rd);
        check("lit_status_err", 64'(rd), 64'h5);
        pulse_done();
        do_txn(BASE + 32'd20, 1'b0, 32'h0, rd);
        check("lit_status_done_err", 64'(rd), 64'h6);

        // Result RAM and reset in mid-transaction
        do_txn(BASE + 4 * INS, 1'b0, 32'h0, rd);
        check("lit_res_read", 64'(rd), 64'hFFFF_FFBC);
        reset_during_req();

        // Unmapped access
        do_txn(BASE + 32'h1000, 1'b0, 32'h0, rd);
        check("lit_unmapped", 64'(rd), 64'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    idx = $urandom_range(0, 4);
                2:       idx = 5;
                3, 4, 5: idx = $urandom_range(6, INS - 1);
                6:       idx = $urandom_range(INS, INS + OUTS - 1);
                7:       idx = $urandom_range(INS + OUTS, 2000);
                default: idx = 32'h3FFF_FFFF - 32'($urandom_range(0, 15));
            endcase
            a = BASE + (idx << 2);
            if (r == 9 && $urandom_range(0, 1) == 1) pulse_done();
            do_txn(a, 1'($urandom_range(0, 1)), $urandom, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
